// File: rtl/wb_stage.sv
// Write-back stage: accepts retiring instructions from MEM, waits for load data,
// aligns/extends it and drives a one-cycle register-file write pulse into decode.
module wb_stage #(
  parameter int WORD_SIZE = 32,
  parameter int REG_SEL   = 5,
  parameter int ADDR_SIZE = 10,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADDR_SIZE-1:0] pc_in,
  input  logic [WORD_SIZE-1:0] alu_result,
  input  logic [REG_SEL-1:0]   rd_in,
  input  logic [2:0]           funct3,
  input  logic                 mem_to_reg_in,
  input  logic                 reg_write_in,
  input  logic                 mem_rvalid,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 reg_write,
  output logic [REG_SEL-1:0]   rd_select,
  output logic [WORD_SIZE-1:0] rd_data,
  output logic                 retire_valid,
  output logic [ADDR_SIZE-1:0] retire_pc,
  output logic [CNT_WIDTH-1:0] retire_count,
  output logic                 busy
);

  typedef enum logic [1:0] {EMPTY, WAIT_MEM, COMMIT} state_t;

  state_t                 state, state_next;
  logic                   take;
  logic [REG_SEL-1:0]     hold_rd;
  logic [2:0]             hold_funct3;
  logic [1:0]             hold_off;
  logic                   hold_we;
  logic [ADDR_SIZE-1:0]   hold_pc;

  logic                   commit_en;
  logic                   commit_we;
  logic [REG_SEL-1:0]     commit_rd;
  logic [WORD_SIZE-1:0]   commit_data;
  logic [ADDR_SIZE-1:0]   commit_pc;

  function automatic logic [WORD_SIZE-1:0] load_extract(
    input logic [2:0]           f3,
    input logic [1:0]           off,
    input logic [WORD_SIZE-1:0] word
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  load_extract = {{(WORD_SIZE-8){b[7]}}, b};
      3'b100:  load_extract = {{(WORD_SIZE-8){1'b0}}, b};
      3'b001:  load_extract = {{(WORD_SIZE-16){h[15]}}, h};
      3'b101:  load_extract = {{(WORD_SIZE-16){1'b0}}, h};
      default: load_extract = word;
    endcase
  endfunction

  assign in_ready = (state == EMPTY) || (state == COMMIT);
  assign take     = in_valid && in_ready;

  // Decide the next state and, when a COMMIT cycle follows, what it writes.
  // NOTE: every signal gets a default first so this block can never infer a latch.
  always_comb begin
    state_next  = state;
    commit_en   = 1'b0;
    commit_we   = 1'b0;
    commit_rd   = hold_rd;
    commit_data = alu_result;
    commit_pc   = hold_pc;
    case (state)
      EMPTY, COMMIT: begin
        state_next = EMPTY;
        if (take) begin
          if (mem_to_reg_in) begin
            state_next = WAIT_MEM;
          end else begin
            state_next  = COMMIT;
            commit_en   = 1'b1;
            commit_we   = reg_write_in && (rd_in != '0);
            commit_rd   = rd_in;
            commit_data = alu_result;
            commit_pc   = pc_in;
          end
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid) begin
          state_next  = COMMIT;
          commit_en   = 1'b1;
          commit_we   = hold_we && (hold_rd != '0);
          commit_data = load_extract(hold_funct3, hold_off, mem_rdata);
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= EMPTY;
      busy         <= 1'b0;
      reg_write    <= 1'b0;
      rd_select    <= '0;
      rd_data      <= '0;
      retire_valid <= 1'b0;
      retire_pc    <= '0;
      retire_count <= '0;
      hold_rd      <= '0;
      hold_funct3  <= '0;
      hold_off     <= '0;
      hold_we      <= 1'b0;
      hold_pc      <= '0;
    end else begin
      state        <= state_next;
      busy         <= (state_next != EMPTY);
      reg_write    <= 1'b0;
      retire_valid <= 1'b0;
      if (take && mem_to_reg_in) begin
        hold_rd     <= rd_in;
        hold_funct3 <= funct3;
        hold_off    <= alu_result[1:0];
        hold_we     <= reg_write_in;
        hold_pc     <= pc_in;
      end
      // rd_select/rd_data/retire_pc only move on a commit, so they hold otherwise.
      if (commit_en) begin
        reg_write    <= commit_we;
        rd_select    <= commit_rd;
        rd_data      <= commit_data;
        retire_valid <= 1'b1;
        retire_pc    <= commit_pc;
        retire_count <= retire_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule
